// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep sequencer and atomic PWM/phase configuration registers
// feeding the DDS/PWM core.
module dds_sweep_ctrl #(
  parameter int FW = 28,
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          loop_mode,
  input  logic [FW-1:0] f_start,
  input  logic [FW-1:0] f_stop,
  input  logic [FW-1:0] f_step,
  input  logic [DW-1:0] dwell,
  input  logic          cfg_load,
  input  logic [11:0]   pword_in,
  input  logic [15:0]   period_in,
  input  logic [15:0]   h_time_in,
  input  logic          pwm_en_in,
  output logic [FW-1:0] fword,
  output logic [11:0]   pword,
  output logic [15:0]   period,
  output logic [15:0]   h_time,
  output logic          pwm_en,
  output logic          busy,
  output logic          done,
  output logic [15:0]   step_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [FW-1:0] sh_start, sh_stop, sh_step;
  logic [DW-1:0] sh_dwell;
  logic          sh_loop;
  logic          load_shadow;
  logic [DW-1:0] cnt, cnt_nxt, dwell_last;
  logic [FW-1:0] fword_nxt;
  logic [15:0]   step_cnt_nxt;
  logic          done_nxt;
  logic          up;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [15:0] clamp_period(input logic [15:0] p);
    return (p == '0) ? 16'd1 : p;
  endfunction

  function automatic logic [15:0] clamp_high(input logic [15:0] h, input logic [15:0] p);
    return (h > p) ? p : h;
  endfunction

  // One sweep step; overshoot, carry or borrow all land exactly on the stop word.
  function automatic logic [FW-1:0] next_freq(input logic [FW-1:0] cur,
                                              input logic [FW-1:0] stop,
                                              input logic [FW-1:0] step,
                                              input logic          dir_up);
    logic [FW:0] t;
    if (step == '0) return stop;
    if (dir_up) begin
      t = {1'b0, cur} + {1'b0, step};
      if (t[FW] || (t[FW-1:0] >= stop)) return stop;
    end else begin
      t = {1'b0, cur} - {1'b0, step};
      if (t[FW] || (t[FW-1:0] <= stop)) return stop;
    end
    return t[FW-1:0];
  endfunction

  assign up         = (sh_stop >= sh_start);
  assign dwell_last = (sh_dwell == '0) ? '0 : sh_dwell - DW'(1);
  assign busy       = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    fword_nxt    = fword;
    cnt_nxt      = cnt;
    step_cnt_nxt = step_cnt;
    done_nxt     = 1'b0;
    load_shadow  = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          load_shadow  = 1'b1;
          fword_nxt    = f_start;
          cnt_nxt      = '0;
          step_cnt_nxt = '0;
          state_nxt    = RUN;
        end
        RUN: if (cnt == dwell_last) begin
          cnt_nxt = '0;
          if (fword != sh_stop) begin
            fword_nxt    = next_freq(fword, sh_stop, sh_step, up);
            step_cnt_nxt = sat_inc16(step_cnt);
          end else begin
            done_nxt = 1'b1;
            if (sh_loop) begin
              fword_nxt    = sh_start;
              step_cnt_nxt = '0;
            end else begin
              state_nxt = IDLE;
            end
          end
        end else begin
          cnt_nxt = cnt + DW'(1);
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Shadow copies are only read in RUN, after a load, so they need no reset.
  always_ff @(posedge clk) begin
    if (load_shadow) begin
      sh_start <= f_start;
      sh_stop  <= f_stop;
      sh_step  <= f_step;
      sh_dwell <= dwell;
      sh_loop  <= loop_mode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fword    <= '0;
      cnt      <= '0;
      step_cnt <= '0;
      done     <= 1'b0;
    end else begin
      fword    <= fword_nxt;
      cnt      <= cnt_nxt;
      step_cnt <= step_cnt_nxt;
      done     <= done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pword  <= '0;
      period <= 16'd1;
      h_time <= '0;
      pwm_en <= 1'b0;
    end else if (cfg_load) begin
      pword  <= pword_in;
      period <= clamp_period(period_in);
      h_time <= clamp_high(h_time_in, clamp_period(period_in));
      pwm_en <= pwm_en_in;
    end
  end

endmodule
